// File: rtl/ram.sv
// 16 x 8 single-port synchronous scratch RAM, flop-based, write-first, registered read.
// Define RAM_PARITY_EN to add per-word even parity and the parity_err output.
module ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
`ifdef RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;

  // Write-first: a read at the address being written returns the new data.
  always_comb begin
    mem_d  = mem_q;
    dout_d = mem_q[addr];
    if (we) begin
      mem_d[addr] = din;
      dout_d      = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef RAM_PARITY_EN
  logic par_q [DEPTH];
  logic par_d [DEPTH];
  logic parity_err_q;
  logic parity_err_d;

  // Stored bit is the XOR of the data, so data plus parity has even weight;
  // the cleared state (data 0, parity 0) is therefore consistent.
  always_comb begin
    par_d        = par_q;
    parity_err_d = (^mem_q[addr]) != par_q[addr];
    if (we) begin
      par_d[addr]  = ^din;
      parity_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q        <= '{default: 1'b0};
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram: reset, read/write, overwrite, write-first, async reset.
// Parity scenario is compiled only when RAM_PARITY_EN is defined.
module tb_ram;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
`ifdef RAM_PARITY_EN
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  ram #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout)
`ifdef RAM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs and samples both happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    #23;
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_dout actual=%h expected=00", dout);
    end
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      tick();
      checks++;
      if (dout !== 8'h00) begin
        failures++;
        $display("FAIL reset_read addr=%0d actual=%h expected=00", a, dout);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; addr = 4'd0; din = 8'h01; tick();
    addr = 4'd1; din = 8'hA5; tick();
    we = 1'b0; addr = 4'd0; din = 8'h00; tick();
    checks++;
    if (dout !== 8'h01) begin
      failures++;
      $display("FAIL wr_rd_addr0 actual=%h expected=01", dout);
    end
    addr = 4'd1; tick();
    checks++;
    if (dout !== 8'hA5) begin
      failures++;
      $display("FAIL wr_rd_addr1 actual=%h expected=a5", dout);
    end
  endtask

  task automatic test_overwrite();
    we = 1'b1; addr = 4'd2; din = 8'h22; tick();
    addr = 4'd0; din = 8'h00; tick();
    din = 8'h01; tick();
    addr = 4'd1; din = 8'hFF; tick();
    we = 1'b0; addr = 4'd0; tick();
    checks++;
    if (dout !== 8'h01) begin
      failures++;
      $display("FAIL overwrite_addr0 actual=%h expected=01", dout);
    end
    addr = 4'd1; tick();
    checks++;
    if (dout !== 8'hFF) begin
      failures++;
      $display("FAIL overwrite_addr1 actual=%h expected=ff", dout);
    end
    addr = 4'd2; tick();
    checks++;
    if (dout !== 8'h22) begin
      failures++;
      $display("FAIL overwrite_neighbour actual=%h expected=22", dout);
    end
  endtask

  task automatic test_read_during_write();
    we = 1'b1; addr = 4'd3; din = 8'h33; tick();
    din = 8'h5C; tick();
    checks++;
    if (dout !== 8'h5C) begin
      failures++;
      $display("FAIL rdw_bypass actual=%h expected=5c", dout);
    end
    we = 1'b0; din = 8'h00; tick();
    checks++;
    if (dout !== 8'h5C) begin
      failures++;
      $display("FAIL rdw_readback actual=%h expected=5c", dout);
    end
  endtask

  task automatic test_async_reset();
    for (int a = 0; a < 16; a++) begin
      we = 1'b1; addr = 4'(a); din = 8'(8'h10 + a); tick();
    end
    we = 1'b0; addr = 4'd5; tick();
    checks++;
    if (dout !== 8'h15) begin
      failures++;
      $display("FAIL fill_read addr=5 actual=%h expected=15", dout);
    end
    // Pending write to addr 7 must be lost when reset hits mid-cycle.
    we = 1'b1; addr = 4'd7; din = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_dout actual=%h expected=00", dout);
    end
    tick();
    #2;
    rst_n = 1'b1;
    we = 1'b0; din = 8'h00;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      tick();
      checks++;
      if (dout !== 8'h00) begin
        failures++;
        $display("FAIL post_reset_read addr=%0d actual=%h expected=00", a, dout);
      end
    end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    we = 1'b1; addr = 4'd2; din = 8'h07; tick();
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_bypass actual=%b expected=0", parity_err);
    end
    we = 1'b0; tick();
    checks++;
    if (dout !== 8'h07 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_clean dout=%h perr=%b expected 07/0", dout, parity_err);
    end
    dut.mem_q[2] = 8'h06;
    tick();
    checks++;
    if (parity_err !== 1'b1) begin
      failures++;
      $display("FAIL parity_flip actual=%b expected=1", parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_overwrite();
    test_read_during_write();
    test_async_reset();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
